hilo_muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit that owns the HI and LO architectural registers; it produces the values consumed by HI_MUX and LO_MUX in the EX/WB path.
- Executes MULT, MULTU, DIV, DIVU iteratively, one bit per cycle.
- Executes MTHI and MTLO in a single cycle.
- Raises busy so the hazard logic stalls MFHI, MFLO and any new mul/div while an operation is in flight.

---
 rtl/hilo_muldiv_unit_pkg.sv | 35 +++
 rtl/hilo_muldiv_unit_iter_core.sv | 69 ++++++
 rtl/hilo_muldiv_unit.sv | 145 ++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op and state encodings,
// default datapath width and small op-decode helpers.
package hilo_muldiv_unit_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_muldiv(input op_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || op_is_div(op);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_iter_core.sv
// Unsigned iterative engine: shift-add multiply or restoring divide, one bit
// per step, on operand magnitudes. Sign handling lives in the parent.
module muldiv_iter_core
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int W = DEF_WIDTH
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic         i_step,
  input  logic         i_is_div,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_last,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Multiply: acc = {partial product, multiplier}; divide: acc = {remainder, quotient}
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_opnd;
  logic [CW-1:0]  r_cnt;
  logic           r_is_div;

  logic [W:0]     w_mul_sum;
  logic [W:0]     w_div_shift;
  logic [W-1:0]   w_div_sub;
  logic           w_div_ge;
  logic [2*W-1:0] w_acc_nxt;

  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_div_shift = r_acc[2*W-1:W-1];
    w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    // Remainder stays below the divisor, so the W-bit difference is exact.
    w_div_sub   = w_div_shift[W-1:0] - r_opnd;
    if (r_is_div)
      w_acc_nxt = {(w_div_ge ? w_div_sub : w_div_shift[W-1:0]), r_acc[W-2:0], w_div_ge};
    else
      w_acc_nxt = {w_mul_sum, r_acc[W-1:1]};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_acc    <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
    end else if (i_load) begin
      r_is_div <= i_is_div;
      r_cnt    <= CNT_INIT;
      r_opnd   <= i_is_div ? i_b : i_a;
      r_acc    <= {{W{1'b0}}, (i_is_div ? i_a : i_b)};
    end else if (i_step) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  assign o_last = (r_cnt == '0);
  assign o_hi   = r_acc[2*W-1:W];
  assign o_lo   = r_acc[W-1:0];

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner: issues mul/div to the iterative core, applies sign correction,
// commits results and handles MTHI/MTLO and divide-by-zero.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_rs_val,
  input  logic [WIDTH-1:0] i_rt_val,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_dz,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  state_e r_state;
  state_e w_state_nxt;

  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  op_e                w_op;
  logic               w_idle;
  logic               w_issue;
  logic               w_is_div;
  logic               w_a_neg;
  logic               w_b_neg;
  logic               w_div_zero;
  logic               w_load;
  logic               w_step;
  logic               w_last;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_core_hi;
  logic [WIDTH-1:0]   w_core_lo;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_hi_fix;
  logic [WIDTH-1:0]   w_lo_fix;

  always_comb begin
    w_op       = op_e'(i_op);
    w_idle     = (r_state == ST_IDLE);
    w_issue    = w_idle && i_start;
    w_is_div   = op_is_div(w_op);
    w_a_neg    = op_is_signed(w_op) && i_rs_val[WIDTH-1];
    w_b_neg    = op_is_signed(w_op) && i_rt_val[WIDTH-1];
    w_a_mag    = w_a_neg ? -i_rs_val : i_rs_val;
    w_b_mag    = w_b_neg ? -i_rt_val : i_rt_val;
    w_div_zero = w_issue && w_is_div && (i_rt_val == '0);
    w_load     = w_issue && op_is_muldiv(w_op) && !w_div_zero;
    w_step     = (r_state == ST_RUN);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_load) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  muldiv_iter_core #(.W(WIDTH)) u_core (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_is_div (w_is_div),
    .i_a      (w_a_mag),
    .i_b      (w_b_mag),
    .o_last   (w_last),
    .o_hi     (w_core_hi),
    .o_lo     (w_core_lo)
  );

  // Magnitude wrap makes MIN / -1 come out as MIN with zero remainder.
  always_comb begin
    w_prod_fix = r_neg_q ? -{w_core_hi, w_core_lo} : {w_core_hi, w_core_lo};
    if (r_is_div) begin
      w_lo_fix = r_neg_q ? -w_core_lo : w_core_lo;
      w_hi_fix = r_neg_r ? -w_core_hi : w_core_hi;
    end else begin
      w_hi_fix = w_prod_fix[2*WIDTH-1:WIDTH];
      w_lo_fix = w_prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      if (w_load) begin
        r_is_div <= w_is_div;
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
        r_busy   <= 1'b1;
      end
      if (w_issue && (w_op == OP_MTHI)) r_hi <= i_rs_val;
      if (w_issue && (w_op == OP_MTLO)) r_lo <= i_rs_val;
      if (w_div_zero) begin
        r_done <= 1'b1;
        r_dz   <= 1'b1;
      end
      if (r_state == ST_FIX) begin
        r_hi   <= w_hi_fix;
        r_lo   <= w_lo_fix;
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_dz   = r_dz;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed literal cases plus random
// issue traffic compared every cycle against an arithmetic model.
module tb_hilo_muldiv_unit;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam int OP_LATENCY = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        done;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;
  logic checking = 1'b0;

  hilo_muldiv_unit dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_start  (start),
    .i_op     (op),
    .i_rs_val (rs),
    .i_rt_val (rt),
    .o_busy   (busy),
    .o_done   (done),
    .o_dz     (dz),
    .o_hi     (hi),
    .o_lo     (lo)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Architectural result {hi, lo} computed with plain 64-bit arithmetic.
  function automatic logic [63:0] model_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint sq;
    longint sr;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    res = '0;
    case (o)
      OP_MULT:  res = 64'(sa * sb);
      OP_MULTU: res = ua * ub;
      OP_DIV: begin
        sq  = sa / sb;
        sr  = sa % sb;
        res = {sr[31:0], sq[31:0]};
      end
      OP_DIVU: begin
        res = ua / ub;
        res = {32'(ua % ub), res[31:0]};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Model: an accepted mul/div occupies the unit for OP_LATENCY cycles, then commits.
  int          m_left;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_res;
  logic        m_done;
  logic        m_dz;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_res  <= '0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
          m_done <= 1'b1;
        end
      end else if (start) begin
        case (op)
          OP_MTHI: m_hi <= rs;
          OP_MTLO: m_lo <= rs;
          OP_MULT, OP_MULTU: begin
            m_res  <= model_res(op, rs, rt);
            m_left <= OP_LATENCY;
          end
          OP_DIV, OP_DIVU: begin
            if (rt == 32'h0) begin
              m_done <= 1'b1;
              m_dz   <= 1'b1;
            end else begin
              m_res  <= model_res(op, rs, rt);
              m_left <= OP_LATENCY;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("cyc_busy", 32'(busy), 32'(m_left > 0));
      check("cyc_done", 32'(done), 32'(m_done));
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
      if (m_done) check("cyc_dz", 32'(dz), 32'(m_dz));
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    @(negedge clk);
    start = 1'b0;
    op    = OP_NONE;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && busy; k++) @(negedge clk);
    check("wait_idle", 32'(busy), 32'h0);
  endtask

  // Issues a mul/div, counts busy cycles, and leaves the bench on the done cycle.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int nbusy;
    issue(o, a, b);
    nbusy = 0;
    for (int k = 0; k < 100 && busy; k++) begin
      nbusy++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 32'(nbusy), 32'(OP_LATENCY));
    check({name, "_done"}, 32'(done), 32'h1);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0;
      1: v = 32'h1;
      2: v = 32'h8000_0000;
      3: v = 32'hFFFF_FFFF;
      4: v = 32'($urandom_range(0, 15));
      default: v = $urandom();
    endcase
    return v;
  endfunction

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = OP_NONE;
    rs    = '0;
    rt    = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_dz", 32'(dz), 32'h0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    rst = 1'b0;
    checking = 1'b1;

    run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    @(negedge clk);
    check("mult_done_pulse", 32'(done), 32'h0);

    run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_dz", 32'(dz), 32'h0);

    run_op("divu", OP_DIVU, 32'hFFFF_FFF9, 32'h0000_0002);
    check("divu_lo", lo, 32'h7FFF_FFFC);
    check("divu_hi", hi, 32'h0000_0001);

    issue(OP_MTHI, 32'h1111_1111, 32'h0);
    issue(OP_MTLO, 32'h2222_2222, 32'h0);
    issue(OP_DIVU, 32'h0000_0064, 32'h0);
    check("dz_done", 32'(done), 32'h1);
    check("dz_flag", 32'(dz), 32'h1);
    check("dz_busy", 32'(busy), 32'h0);
    check("dz_hi", hi, 32'h1111_1111);
    check("dz_lo", lo, 32'h2222_2222);
    @(negedge clk);
    check("dz_done_pulse", 32'(done), 32'h0);

    run_op("ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0000_0000);
    check("ovf_dz", 32'(dz), 32'h0);

    issue(OP_MULTU, 32'd5, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1;
    op    = OP_DIVU;
    rs    = 32'd100;
    rt    = 32'd3;
    @(negedge clk);
    start = 1'b0;
    op    = OP_NONE;
    wait_idle();
    check("ign_hi", hi, 32'h0);
    check("ign_lo", lo, 32'h23);

    issue(OP_MTHI, 32'hAAAA_5555, 32'h0);
    issue(OP_MULTU, 32'd5, 32'd7);
    repeat (9) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_hi", hi, 32'h0);
    check("async_rst_lo", lo, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    issue(OP_MTHI, 32'h1234_5678, 32'h0);
    check("mthi_after_rst", hi, 32'h1234_5678);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      op    = 3'($urandom_range(0, 7));
      rs    = pick();
      rt    = pick();
    end
    @(negedge clk);
    start = 1'b0;
    op    = OP_NONE;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
